// File: rtl/fifo_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_access_arbiter                                          |
// | Description : Grants two writers and one reader access to a shared FIFO.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_access_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        wr_req,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              rd_req,
   input  logic              fifo_full,
   input  logic              fifo_empty,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_din,
   output logic              fifo_rd_en,
   output logic [1:0]        wr_ack,
   output logic [1:0]        wr_err,
   output logic              rd_ack,
   output logic              rd_err,
   output logic              arb_busy
);

   localparam logic [2:0] c_IDLE   = 3'b000;
   localparam logic [2:0] c_WR0    = 3'b001;
   localparam logic [2:0] c_WR1    = 3'b010;
   localparam logic [2:0] c_RD     = 3'b011;
   localparam logic [2:0] c_WR_ERR = 3'b100;
   localparam logic [2:0] c_RD_ERR = 3'b101;

   localparam logic c_CLS_READ  = 1'b0;
   localparam logic c_CLS_WRITE = 1'b1;

   logic [2:0]        r_state;
   logic [2:0]        w_next_state;
   logic              r_rr_last;
   logic              w_rr_last_next;
   logic              r_last_cls;
   logic              w_last_cls_next;

   logic              w_wr_pend;
   logic              w_take_read;
   logic              w_take_write;
   logic              w_wr_sel;

   logic              r_fifo_wr_en, w_fifo_wr_en;
   logic [DATA_W-1:0] r_fifo_din,   w_fifo_din;
   logic              r_fifo_rd_en, w_fifo_rd_en;
   logic [1:0]        r_wr_ack,     w_wr_ack;
   logic [1:0]        r_wr_err,     w_wr_err;
   logic              r_rd_ack,     w_rd_ack;
   logic              r_rd_err,     w_rd_err;
   logic              r_arb_busy,   w_arb_busy;

   // Class alternation only matters when both classes are pending at once.
   assign w_wr_pend    = |wr_req;
   assign w_take_read  = rd_req && (!w_wr_pend || (r_last_cls == c_CLS_WRITE));
   assign w_take_write = w_wr_pend && !w_take_read;
   assign w_wr_sel     = (wr_req == 2'b11) ? ~r_rr_last : wr_req[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= c_IDLE;
         r_rr_last    <= 1'b1;
         r_last_cls   <= c_CLS_READ;
         r_fifo_wr_en <= 1'b0;
         r_fifo_din   <= '0;
         r_fifo_rd_en <= 1'b0;
         r_wr_ack     <= 2'b00;
         r_wr_err     <= 2'b00;
         r_rd_ack     <= 1'b0;
         r_rd_err     <= 1'b0;
         r_arb_busy   <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_rr_last    <= w_rr_last_next;
         r_last_cls   <= w_last_cls_next;
         r_fifo_wr_en <= w_fifo_wr_en;
         r_fifo_din   <= w_fifo_din;
         r_fifo_rd_en <= w_fifo_rd_en;
         r_wr_ack     <= w_wr_ack;
         r_wr_err     <= w_wr_err;
         r_rd_ack     <= w_rd_ack;
         r_rd_err     <= w_rd_err;
         r_arb_busy   <= w_arb_busy;
      end
   end

   always_comb begin
      w_next_state    = c_IDLE;
      w_rr_last_next  = r_rr_last;
      w_last_cls_next = r_last_cls;
      case (r_state)
         c_IDLE: begin
            if (w_take_read) begin
               w_last_cls_next = c_CLS_READ;
               w_next_state    = fifo_empty ? c_RD_ERR : c_RD;
            end else if (w_take_write) begin
               w_last_cls_next = c_CLS_WRITE;
               w_rr_last_next  = w_wr_sel;
               if (fifo_full)
                  w_next_state = c_WR_ERR;
               else
                  w_next_state = w_wr_sel ? c_WR1 : c_WR0;
            end
         end
         default: w_next_state = c_IDLE;
      endcase
   end

   // Outputs are decoded from the state being entered so they appear registered.
   always_comb begin
      w_fifo_wr_en = 1'b0;
      w_fifo_din   = r_fifo_din;
      w_fifo_rd_en = 1'b0;
      w_wr_ack     = 2'b00;
      w_wr_err     = 2'b00;
      w_rd_ack     = 1'b0;
      w_rd_err     = 1'b0;
      w_arb_busy   = (w_next_state != c_IDLE);
      case (w_next_state)
         c_WR0: begin
            w_fifo_wr_en = 1'b1;
            w_fifo_din   = wr_data0;
            w_wr_ack     = 2'b01;
         end
         c_WR1: begin
            w_fifo_wr_en = 1'b1;
            w_fifo_din   = wr_data1;
            w_wr_ack     = 2'b10;
         end
         c_RD: begin
            w_fifo_rd_en = 1'b1;
            w_rd_ack     = 1'b1;
         end
         c_WR_ERR: w_wr_err = w_rr_last_next ? 2'b10 : 2'b01;
         c_RD_ERR: w_rd_err = 1'b1;
         default: ;
      endcase
   end

   assign fifo_wr_en = r_fifo_wr_en;
   assign fifo_din   = r_fifo_din;
   assign fifo_rd_en = r_fifo_rd_en;
   assign wr_ack     = r_wr_ack;
   assign wr_err     = r_wr_err;
   assign rd_ack     = r_rd_ack;
   assign rd_err     = r_rd_err;
   assign arb_busy   = r_arb_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_access_arbiter                                       |
// | Description : Randomized requesters and FIFO occupancy vs reference model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fifo_access_arbiter;

   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [1:0]        wr_req;
   logic [DATA_W-1:0] wr_data0, wr_data1;
   logic              rd_req, fifo_full, fifo_empty;
   logic              fifo_wr_en, fifo_rd_en, rd_ack, rd_err, arb_busy;
   logic [DATA_W-1:0] fifo_din;
   logic [1:0]        wr_ack, wr_err;

   fifo_access_arbiter #(.DATA_W(DATA_W)) dut (
      .clk(clk), .reset_n(reset_n), .wr_req(wr_req), .wr_data0(wr_data0),
      .wr_data1(wr_data1), .rd_req(rd_req), .fifo_full(fifo_full),
      .fifo_empty(fifo_empty), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
      .fifo_rd_en(fifo_rd_en), .wr_ack(wr_ack), .wr_err(wr_err),
      .rd_ack(rd_ack), .rd_err(rd_err), .arb_busy(arb_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int count;                 // FIFO occupancy seen by the requesters

   // Reference model: one grant, then a mandatory idle slot
   bit                m_cooldown;
   bit                m_last_read;
   int                m_last_writer;
   logic [DATA_W-1:0] m_din;

   logic              e_wr_en, e_rd_en, e_rd_ack, e_rd_err, e_busy;
   logic [1:0]        e_wr_ack, e_wr_err;
   logic [DATA_W-1:0] e_din;

   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clear_expected();
      e_wr_en = 0; e_rd_en = 0; e_rd_ack = 0; e_rd_err = 0; e_busy = 0;
      e_wr_ack = 0; e_wr_err = 0; e_din = m_din;
   endtask

   task automatic model_reset();
      m_cooldown = 0; m_last_read = 1; m_last_writer = 1; m_din = '0;
      clear_expected();
   endtask

   task automatic predict();
      bit want_w, want_r, do_read;
      int w;
      clear_expected();
      want_w = (wr_req != 2'b00);
      want_r = rd_req;
      if (m_cooldown) begin
         m_cooldown = 0;
      end else if (want_w || want_r) begin
         do_read     = want_r && (!want_w || !m_last_read);
         m_cooldown  = 1;
         e_busy      = 1;
         m_last_read = do_read;
         if (do_read) begin
            if (count == 0) e_rd_err = 1;
            else begin e_rd_en = 1; e_rd_ack = 1; end
         end else begin
            w = (wr_req == 2'b11) ? 1 - m_last_writer : (wr_req[1] ? 1 : 0);
            m_last_writer = w;
            if (count == 32) e_wr_err[w] = 1'b1;
            else begin
               e_wr_ack[w] = 1'b1;
               e_wr_en     = 1;
               m_din       = (w == 1) ? wr_data1 : wr_data0;
               e_din       = m_din;
            end
         end
      end
   endtask

   task automatic compare();
      check("fifo_wr_en", {31'd0, fifo_wr_en}, {31'd0, e_wr_en});
      check("fifo_din",   fifo_din,            e_din);
      check("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, e_rd_en});
      check("wr_ack",     {30'd0, wr_ack},     {30'd0, e_wr_ack});
      check("wr_err",     {30'd0, wr_err},     {30'd0, e_wr_err});
      check("rd_ack",     {31'd0, rd_ack},     {31'd0, e_rd_ack});
      check("rd_err",     {31'd0, rd_err},     {31'd0, e_rd_err});
      check("arb_busy",   {31'd0, arb_busy},   {31'd0, e_busy});
   endtask

   // Requesters drop req on seeing ack/err; idle ones re-raise at random.
   task automatic update_env(input int pw, input int pr);
      if (e_wr_en) count++;
      if (e_rd_en) count--;
      for (int i = 0; i < 2; i++) begin
         if (e_wr_ack[i] || e_wr_err[i]) wr_req[i] = 1'b0;
         else if (!wr_req[i] && ($urandom_range(99) < pw)) begin
            wr_req[i] = 1'b1;
            if (i == 0) wr_data0 = $urandom; else wr_data1 = $urandom;
         end
      end
      if (e_rd_ack || e_rd_err) rd_req = 1'b0;
      else if (!rd_req && ($urandom_range(99) < pr)) rd_req = 1'b1;
      fifo_full  = (count == 32);
      fifo_empty = (count == 0);
   endtask

   task automatic cycle(input int pw, input int pr);
      predict();
      @(posedge clk);
      @(negedge clk);
      compare();
      update_env(pw, pr);
   endtask

   initial begin
      reset_n = 0; wr_req = 0; rd_req = 0; wr_data0 = 0; wr_data1 = 0;
      count = 0; fifo_full = 0; fifo_empty = 1;
      model_reset();
      repeat (2) @(negedge clk);
      compare();

      // Single writer, known data
      wr_req = 2'b01; wr_data0 = 32'h0000_00A5;
      reset_n = 1;
      cycle(0, 0);
      check("t1_din", fifo_din, 32'h0000_00A5);
      repeat (3) cycle(0, 0);

      // Both writers contending continuously
      wr_req = 2'b11; wr_data0 = $urandom; wr_data1 = $urandom;
      repeat (10) cycle(100, 0);
      repeat (4) cycle(0, 0);

      // Write-heavy drives the FIFO to full, read-heavy drains to empty
      repeat (300) cycle(80, 10);
      repeat (300) cycle(10, 80);
      repeat (400) cycle(50, 50);
      repeat (100) cycle(90, 90);

      // Quiesce, then reset while a WR1 grant is in flight
      for (int i = 0; i < 20 && (wr_req != 0 || rd_req || m_cooldown); i++) cycle(0, 0);
      wr_req = 2'b10; wr_data1 = $urandom; rd_req = 0;
      predict();
      @(posedge clk);
      #2 reset_n = 0;
      #1 model_reset();
      compare();
      @(negedge clk);
      reset_n = 1;
      fifo_full  = (count == 32);
      fifo_empty = (count == 0);
      repeat (4) cycle(0, 0);
      repeat (200) cycle(60, 60);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
